// File: rtl/elpis_mem_pkg.sv
// Shared types and sizing helpers for the Elpis line memory controller.
// Optional byte-mask support in line_mem_ctrl is enabled by defining MEM_BYTE_MASK_EN.
package elpis_mem_pkg;

    localparam int DEF_LINE_W      = 128;
    localparam int DEF_WORD_W      = 32;
    localparam int DEF_ADDR_W      = 20;
    localparam int DEF_SRAM_ADDR_W = 11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    function automatic int calc_beats(input int line_w, input int word_w);
        return line_w / word_w;
    endfunction

    // One extra bit so the counter can represent BEATS itself.
    function automatic int calc_beat_cnt_w(input int beats);
        return $clog2(beats) + 1;
    endfunction

    function automatic int calc_idx_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/line_beat_assembler.sv
// Beat-indexed capture register: builds a line from individual SRAM words.
// Words that are not written keep their previous contents.
module line_beat_assembler #(
    parameter int LINE_W = 128,
    parameter int WORD_W = 32,
    parameter int IDX_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [WORD_W-1:0] din,
    output logic [LINE_W-1:0] line
);

    localparam int BEATS = LINE_W / WORD_W;

    logic [BEATS-1:0][WORD_W-1:0] words;

    always_ff @(posedge clk) begin
        if (reset) begin
            words <= '0;
        end else if (we) begin
            words[idx] <= din;
        end
    end

    assign line = words;

endmodule

// File: rtl/line_mem_ctrl.sv
// Multi-beat line controller between the cache/core side and one single-port SRAM.
// Define MEM_BYTE_MASK_EN to add per-byte write masks (req_wmask / sram_wmask).
module line_mem_ctrl
    import elpis_mem_pkg::*;
#(
    parameter int LINE_W      = DEF_LINE_W,
    parameter int WORD_W      = DEF_WORD_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int SRAM_ADDR_W = DEF_SRAM_ADDR_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [LINE_W-1:0]      req_wdata,
`ifdef MEM_BYTE_MASK_EN
    input  logic [LINE_W/8-1:0]    req_wmask,
    output logic [WORD_W/8-1:0]    sram_wmask,
`endif
    input  logic                   abort,
    output logic                   rsp_valid,
    output logic [LINE_W-1:0]      rd_data,
    input  logic                   ld_en,
    input  logic [ADDR_W-1:0]      ld_addr,
    input  logic [WORD_W-1:0]      ld_data,
    output logic                   sram_csb,
    output logic                   sram_web,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [WORD_W-1:0]      sram_din,
    input  logic [WORD_W-1:0]      sram_dout
);

    localparam int BEATS      = calc_beats(LINE_W, WORD_W);
    localparam int BEAT_CNT_W = calc_beat_cnt_w(BEATS);
    localparam int IDX_W      = calc_idx_w(BEATS);

    state_t                       state;
    logic [BEAT_CNT_W-1:0]        beat_cnt;
    logic [ADDR_W-1:0]            lat_addr;
    logic [BEATS-1:0][WORD_W-1:0] lat_wdata;
`ifdef MEM_BYTE_MASK_EN
    logic [BEATS-1:0][WORD_W/8-1:0] lat_wmask;
`endif
    logic                         rd_pending;
    logic [IDX_W-1:0]             cap_idx;

    logic [IDX_W-1:0]             beat_idx;
    logic                         last_beat;
    logic [ADDR_W-1:0]            beat_addr;
    logic                         fsm_issue;
    logic                         capture_en;
    logic                         unused_addr_bits;

    assign beat_idx  = beat_cnt[IDX_W-1:0];
    assign last_beat = (beat_cnt == BEAT_CNT_W'(BEATS - 1));
    assign beat_addr = lat_addr + ADDR_W'(beat_cnt);
    assign fsm_issue = ((state == ST_WRITE) || (state == ST_READ)) && !ld_en && !abort && !reset;
    assign capture_en = rd_pending && !abort && !reset;

    assign unused_addr_bits = ^{beat_addr[ADDR_W-1:SRAM_ADDR_W], ld_addr[ADDR_W-1:SRAM_ADDR_W]};

    assign req_ready = !reset && (state == ST_IDLE) && !ld_en && !abort;
    assign rsp_valid = !reset && (state == ST_RESP) && !abort;

    // SRAM port mux: the loader always wins, otherwise the current beat is issued.
    always_comb begin
        sram_csb  = 1'b1;
        sram_web  = 1'b1;
        sram_addr = '0;
        sram_din  = '0;
`ifdef MEM_BYTE_MASK_EN
        sram_wmask = '0;
`endif
        if (!reset && ld_en) begin
            sram_csb  = 1'b0;
            sram_web  = 1'b0;
            sram_addr = ld_addr[SRAM_ADDR_W-1:0];
            sram_din  = ld_data;
`ifdef MEM_BYTE_MASK_EN
            sram_wmask = '1;
`endif
        end else if (fsm_issue) begin
            sram_csb  = 1'b0;
            sram_addr = beat_addr[SRAM_ADDR_W-1:0];
            if (state == ST_WRITE) begin
                sram_din = lat_wdata[beat_idx];
`ifdef MEM_BYTE_MASK_EN
                sram_wmask = lat_wmask[beat_idx];
                sram_web   = (lat_wmask[beat_idx] == '0);
`else
                sram_web   = 1'b0;
`endif
            end
        end
    end

    // Sequencer: beat counter holds while the loader owns the port.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            beat_cnt   <= '0;
            rd_pending <= 1'b0;
            cap_idx    <= '0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
`ifdef MEM_BYTE_MASK_EN
            lat_wmask  <= '0;
`endif
        end else if (abort) begin
            state      <= ST_IDLE;
            beat_cnt   <= '0;
            rd_pending <= 1'b0;
        end else begin
            rd_pending <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (req_valid && !ld_en) begin
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
`ifdef MEM_BYTE_MASK_EN
                        lat_wmask <= req_wmask;
`endif
                        beat_cnt  <= '0;
                        state     <= req_we ? ST_WRITE : ST_READ;
                    end
                end
                ST_WRITE: begin
                    if (!ld_en) begin
                        if (last_beat) begin
                            beat_cnt <= '0;
                            state    <= ST_RESP;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (!ld_en) begin
                        rd_pending <= 1'b1;
                        cap_idx    <= beat_idx;
                        if (last_beat) begin
                            beat_cnt <= '0;
                            state    <= ST_DRAIN;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!ld_en) begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    line_beat_assembler #(
        .LINE_W (LINE_W),
        .WORD_W (WORD_W),
        .IDX_W  (IDX_W)
    ) u_assembler (
        .clk   (clk),
        .reset (reset),
        .we    (capture_en),
        .idx   (cap_idx),
        .din   (sram_dout),
        .line  (rd_data)
    );

endmodule

// File: tb/tb_line_mem_ctrl.sv
// Self-checking bench for line_mem_ctrl: SRAM behavioural model plus a word-array reference
// that applies the line-to-beat rules directly.
module tb_line_mem_ctrl;

    localparam int NCYC = 12;

    logic         clk;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic         req_we;
    logic [19:0]  req_addr;
    logic [127:0] req_wdata;
    logic         abort;
    logic         rsp_valid;
    logic [127:0] rd_data;
    logic         ld_en;
    logic [19:0]  ld_addr;
    logic [31:0]  ld_data;
    logic         sram_csb;
    logic         sram_web;
    logic [10:0]  sram_addr;
    logic [31:0]  sram_din;
    logic [31:0]  sram_dout;
`ifdef MEM_BYTE_MASK_EN
    logic [15:0]  req_wmask;
    logic [3:0]   sram_wmask;
    assign req_wmask = '1;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0]  mem     [0:2047];
    logic [31:0]  ref_mem [0:2047];

    logic         handshake_ok;
    logic         rsp_log   [0:NCYC];
    logic         ready_log [0:NCYC];
    logic         csb_log   [0:NCYC];
    logic [127:0] rd_log    [0:NCYC];
    logic [10:0]  addr_log  [$];

    line_mem_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
`ifdef MEM_BYTE_MASK_EN
        .req_wmask (req_wmask),
        .sram_wmask(sram_wmask),
`endif
        .abort     (abort),
        .rsp_valid (rsp_valid),
        .rd_data   (rd_data),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .sram_csb  (sram_csb),
        .sram_web  (sram_web),
        .sram_addr (sram_addr),
        .sram_din  (sram_din),
        .sram_dout (sram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port SRAM: read data appears the cycle after the address.
    always @(posedge clk) begin
        if (!sram_csb) begin
            if (!sram_web) mem[sram_addr] <= sram_din;
            else           sram_dout      <= mem[sram_addr];
        end
    end

    function automatic void model_write(input logic [19:0] addr, input logic [127:0] line);
        logic [19:0] a;
        for (int k = 0; k < 4; k++) begin
            a = addr + 20'(k);
            ref_mem[a[10:0]] = line[k*32 +: 32];
        end
    endfunction

    function automatic logic [127:0] model_line(input logic [19:0] addr);
        logic [127:0] line;
        logic [19:0]  a;
        for (int k = 0; k < 4; k++) begin
            a = addr + 20'(k);
            line[k*32 +: 32] = ref_mem[a[10:0]];
        end
        return line;
    endfunction

    function automatic logic [127:0] sram_line(input logic [19:0] addr);
        logic [127:0] line;
        logic [19:0]  a;
        for (int k = 0; k < 4; k++) begin
            a = addr + 20'(k);
            line[k*32 +: 32] = mem[a[10:0]];
        end
        return line;
    endfunction

    function automatic int rsp_first();
        for (int n = 1; n <= NCYC; n++) if (rsp_log[n] === 1'b1) return n;
        return 0;
    endfunction

    function automatic int rsp_count();
        int c = 0;
        for (int n = 1; n <= NCYC; n++) if (rsp_log[n] === 1'b1) c++;
        return c;
    endfunction

    // Runs one request for NCYC cycles after the handshake cycle, with optional loader/abort/reset.
    task automatic drive_req(input logic we, input logic [19:0] addr, input logic [127:0] wdata,
                             input int ld_start, input int ld_len, input logic [19:0] ldaddr,
                             input logic [31:0] lddata, input int abort_at, input int reset_at);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        #1;
        handshake_ok = req_ready;
        addr_log.delete();
        for (int n = 1; n <= NCYC; n++) begin
            @(negedge clk);
            req_valid = 1'b0;
            ld_en     = (n >= ld_start) && (n < ld_start + ld_len);
            ld_addr   = ldaddr;
            ld_data   = lddata;
            abort     = (n == abort_at);
            reset     = (n == reset_at);
            if (ld_en) ref_mem[ldaddr[10:0]] = lddata;
            #1;
            rsp_log[n]   = rsp_valid;
            ready_log[n] = req_ready;
            csb_log[n]   = sram_csb;
            rd_log[n]    = rd_data;
            if (!sram_csb && !ld_en && !reset) addr_log.push_back(sram_addr);
        end
        @(negedge clk);
        ld_en = 1'b0;
        abort = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready_low: got %b expected 0", req_ready); end
        checks++;
        if (sram_csb !== 1'b1) begin errors++; $display("[TB] FAIL reset_csb: got %b expected 1", sram_csb); end
        reset = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp: got %b expected 0", rsp_valid); end
        checks++;
        if (rd_data !== 128'h0) begin errors++; $display("[TB] FAIL reset_rd_data: got %h expected 0", rd_data); end
        checks++;
        if (req_ready !== 1'b1 || sram_web !== 1'b1) begin
            errors++; $display("[TB] FAIL reset_idle: got ready=%b web=%b expected ready=1 web=1", req_ready, sram_web);
        end
    endtask

    task automatic test_write();
        logic [127:0] line = 128'h44444444_33333333_22222222_11111111;
        drive_req(1'b1, 20'h00010, line, 99, 0, 20'h0, 32'h0, 99, 99);
        model_write(20'h00010, line);
        checks++;
        if (handshake_ok !== 1'b1) begin errors++; $display("[TB] FAIL write_handshake: got %b expected 1", handshake_ok); end
        checks++;
        if (rsp_first() != 5 || rsp_count() != 1) begin
            errors++; $display("[TB] FAIL write_rsp: got first=%0d count=%0d expected first=5 count=1", rsp_first(), rsp_count());
        end
        checks++;
        if ({mem[11'h13], mem[11'h12], mem[11'h11], mem[11'h10]} !== line) begin
            errors++; $display("[TB] FAIL write_mem: got %h expected %h", {mem[11'h13], mem[11'h12], mem[11'h11], mem[11'h10]}, line);
        end
        checks++;
        if (ready_log[1] !== 1'b0 || ready_log[6] !== 1'b1) begin
            errors++; $display("[TB] FAIL write_ready: got T1=%b T6=%b expected T1=0 T6=1", ready_log[1], ready_log[6]);
        end
    endtask

    task automatic test_read();
        logic [127:0] exp = 128'h44444444_33333333_22222222_11111111;
        drive_req(1'b0, 20'h00010, 128'h0, 99, 0, 20'h0, 32'h0, 99, 99);
        checks++;
        if (rsp_first() != 6 || rsp_count() != 1) begin
            errors++; $display("[TB] FAIL read_rsp: got first=%0d count=%0d expected first=6 count=1", rsp_first(), rsp_count());
        end
        checks++;
        if (rd_log[6] !== exp) begin errors++; $display("[TB] FAIL read_data: got %h expected %h", rd_log[6], exp); end
        checks++;
        if (rd_log[NCYC] !== exp) begin errors++; $display("[TB] FAIL read_hold: got %h expected %h", rd_log[NCYC], exp); end
    endtask

    task automatic test_wrap();
        logic [127:0] line = {$urandom, $urandom, $urandom, $urandom};
        drive_req(1'b1, 20'h007FE, line, 99, 0, 20'h0, 32'h0, 99, 99);
        model_write(20'h007FE, line);
        checks++;
        if (sram_line(20'h007FE) !== model_line(20'h007FE)) begin
            errors++; $display("[TB] FAIL wrap_write_mem: got %h expected %h", sram_line(20'h007FE), model_line(20'h007FE));
        end
        drive_req(1'b0, 20'h007FE, 128'h0, 99, 0, 20'h0, 32'h0, 99, 99);
        checks++;
        if (addr_log.size() != 4 || addr_log[0] !== 11'h7FE || addr_log[1] !== 11'h7FF ||
            addr_log[2] !== 11'h000 || addr_log[3] !== 11'h001) begin
            errors++; $display("[TB] FAIL wrap_addr_seq: got %p expected 7fe 7ff 000 001", addr_log);
        end
        checks++;
        if (rd_log[6] !== line) begin errors++; $display("[TB] FAIL wrap_read_data: got %h expected %h", rd_log[6], line); end
    endtask

    task automatic test_loader();
        logic [127:0] line = {$urandom, $urandom, $urandom, $urandom};
        logic [31:0]  lword = $urandom;
        drive_req(1'b1, 20'h00200, line, 99, 0, 20'h0, 32'h0, 99, 99);
        model_write(20'h00200, line);
        drive_req(1'b0, 20'h00200, 128'h0, 3, 3, 20'h00500, lword, 99, 99);
        checks++;
        if (rsp_first() != 9 || rsp_count() != 1) begin
            errors++; $display("[TB] FAIL loader_rsp: got first=%0d count=%0d expected first=9 count=1", rsp_first(), rsp_count());
        end
        checks++;
        if (rd_log[9] !== model_line(20'h00200)) begin
            errors++; $display("[TB] FAIL loader_read_data: got %h expected %h", rd_log[9], model_line(20'h00200));
        end
        checks++;
        if (mem[11'h500] !== ref_mem[11'h500]) begin
            errors++; $display("[TB] FAIL loader_write: got %h expected %h", mem[11'h500], ref_mem[11'h500]);
        end
    endtask

    task automatic test_abort();
        drive_req(1'b0, 20'h00010, 128'h0, 99, 0, 20'h0, 32'h0, 3, 99);
        checks++;
        if (rsp_count() != 0) begin errors++; $display("[TB] FAIL abort_no_rsp: got count=%0d expected 0", rsp_count()); end
        checks++;
        if (ready_log[4] !== 1'b1 || csb_log[4] !== 1'b1) begin
            errors++; $display("[TB] FAIL abort_idle: got ready=%b csb=%b expected ready=1 csb=1", ready_log[4], csb_log[4]);
        end
        checks++;
        if (rd_log[4][31:0] !== ref_mem[11'h010]) begin
            errors++; $display("[TB] FAIL abort_partial: got %h expected %h", rd_log[4][31:0], ref_mem[11'h010]);
        end
    endtask

    task automatic test_reset_mid_write();
        drive_req(1'b1, 20'h00400, {$urandom, $urandom, $urandom, $urandom}, 99, 0, 20'h0, 32'h0, 99, 2);
        checks++;
        if (ready_log[2] !== 1'b0) begin errors++; $display("[TB] FAIL midreset_ready_low: got %b expected 0", ready_log[2]); end
        checks++;
        if (rsp_count() != 0) begin errors++; $display("[TB] FAIL midreset_no_rsp: got count=%0d expected 0", rsp_count()); end
        checks++;
        if (rd_log[3] !== 128'h0 || csb_log[3] !== 1'b1 || ready_log[3] !== 1'b1) begin
            errors++; $display("[TB] FAIL midreset_idle: got rd=%h csb=%b ready=%b expected rd=0 csb=1 ready=1",
                               rd_log[3], csb_log[3], ready_log[3]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            logic [19:0]  addr = 20'($urandom_range(0, 20'hFFFFF));
            logic [127:0] line = {$urandom, $urandom, $urandom, $urandom};
            int           lstart = $urandom_range(1, 4);
            int           llen   = $urandom_range(0, 2);
            logic [31:0]  lword  = $urandom;
            drive_req(1'b1, addr, line, 99, 0, 20'h0, 32'h0, 99, 99);
            model_write(addr, line);
            checks++;
            if (rsp_first() != 5 || sram_line(addr) !== model_line(addr)) begin
                errors++; $display("[TB] FAIL rand_write[%0d]: got first=%0d mem=%h expected first=5 mem=%h",
                                   i, rsp_first(), sram_line(addr), model_line(addr));
            end
            drive_req(1'b0, addr, 128'h0, lstart, llen, addr + 20'h00400, lword, 99, 99);
            checks++;
            if (rsp_first() != 6 + llen || rsp_count() != 1 || rd_log[6 + llen] !== model_line(addr)) begin
                errors++; $display("[TB] FAIL rand_read[%0d]: got first=%0d count=%0d data=%h expected first=%0d count=1 data=%h",
                                   i, rsp_first(), rsp_count(), rd_log[6 + llen], 6 + llen, model_line(addr));
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        abort     = 1'b0;
        ld_en     = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;
        test_reset();
        test_write();
        test_read();
        test_wrap();
        test_loader();
        test_abort();
        test_reset_mid_write();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
